// File: rtl/lc3b_microsequencer_pkg.sv
// LC-3b control-unit package: microstate codes, control-word field layout
// and the microcode control store.
package lc3b_ctrl_pkg;

    localparam int unsigned STATE_W     = 6;
    localparam int unsigned CW_W        = 26;
    localparam int unsigned RESET_STATE = 18;

    typedef enum logic [1:0] {
        COND_NONE  = 2'b00,
        COND_MEM_R = 2'b01,
        COND_BEN   = 2'b10,
        COND_IR11  = 2'b11
    } cond_e;

    typedef struct packed {
        logic [CW_W-1:0]    cw;
        logic               ird;
        cond_e              cond;
        logic [STATE_W-1:0] j;
    } uinst_t;

    localparam logic [STATE_W-1:0] S_BR        = 6'd0;
    localparam logic [STATE_W-1:0] S_ADD       = 6'd1;
    localparam logic [STATE_W-1:0] S_LDB       = 6'd2;
    localparam logic [STATE_W-1:0] S_STB       = 6'd3;
    localparam logic [STATE_W-1:0] S_JSR       = 6'd4;
    localparam logic [STATE_W-1:0] S_AND       = 6'd5;
    localparam logic [STATE_W-1:0] S_LDW       = 6'd6;
    localparam logic [STATE_W-1:0] S_STW       = 6'd7;
    localparam logic [STATE_W-1:0] S_XOR       = 6'd9;
    localparam logic [STATE_W-1:0] S_JMP       = 6'd12;
    localparam logic [STATE_W-1:0] S_SHF       = 6'd13;
    localparam logic [STATE_W-1:0] S_LEA       = 6'd14;
    localparam logic [STATE_W-1:0] S_TRAP      = 6'd15;
    localparam logic [STATE_W-1:0] S_STW_MEM   = 6'd16;
    localparam logic [STATE_W-1:0] S_STB_MEM   = 6'd17;
    localparam logic [STATE_W-1:0] S_FETCH0    = 6'd18;
    localparam logic [STATE_W-1:0] S_STB_DONE  = 6'd19;
    localparam logic [STATE_W-1:0] S_JSRR      = 6'd20;
    localparam logic [STATE_W-1:0] S_JSR_OFF   = 6'd21;
    localparam logic [STATE_W-1:0] S_BR_TAKEN  = 6'd22;
    localparam logic [STATE_W-1:0] S_STW_MDR   = 6'd23;
    localparam logic [STATE_W-1:0] S_STB_MDR   = 6'd24;
    localparam logic [STATE_W-1:0] S_LDW_MEM   = 6'd25;
    localparam logic [STATE_W-1:0] S_LDW_WB    = 6'd27;
    localparam logic [STATE_W-1:0] S_TRAP_MEM  = 6'd28;
    localparam logic [STATE_W-1:0] S_LDB_MEM   = 6'd29;
    localparam logic [STATE_W-1:0] S_TRAP_PC   = 6'd30;
    localparam logic [STATE_W-1:0] S_LDB_WB    = 6'd31;
    localparam logic [STATE_W-1:0] S_DECODE    = 6'd32;
    localparam logic [STATE_W-1:0] S_FETCH1    = 6'd33;
    localparam logic [STATE_W-1:0] S_FETCH2    = 6'd35;

    // Control-word bit positions (multi-bit fields give their LSB)
    localparam int unsigned B_LD_MAR      = 25;
    localparam int unsigned B_LD_MDR      = 24;
    localparam int unsigned B_LD_IR       = 23;
    localparam int unsigned B_LD_BEN      = 22;
    localparam int unsigned B_LD_REG      = 21;
    localparam int unsigned B_LD_CC       = 20;
    localparam int unsigned B_LD_PC       = 19;
    localparam int unsigned B_GATE_PC     = 18;
    localparam int unsigned B_GATE_MDR    = 17;
    localparam int unsigned B_GATE_ALU    = 16;
    localparam int unsigned B_GATE_MARMUX = 15;
    localparam int unsigned B_GATE_SHF    = 14;
    localparam int unsigned B_PCMUX       = 12;
    localparam int unsigned B_DRMUX       = 11;
    localparam int unsigned B_SR1MUX      = 10;
    localparam int unsigned B_ADDR1MUX    = 9;
    localparam int unsigned B_ADDR2MUX    = 7;
    localparam int unsigned B_MARMUX      = 6;
    localparam int unsigned B_ALUK        = 4;
    localparam int unsigned B_MIO_EN      = 3;
    localparam int unsigned B_R_W         = 2;
    localparam int unsigned B_DATA_SIZE   = 1;
    localparam int unsigned B_LSHF1       = 0;

    localparam logic [CW_W-1:0] LD_MAR       = CW_W'(1) << B_LD_MAR;
    localparam logic [CW_W-1:0] LD_MDR       = CW_W'(1) << B_LD_MDR;
    localparam logic [CW_W-1:0] LD_IR        = CW_W'(1) << B_LD_IR;
    localparam logic [CW_W-1:0] LD_BEN       = CW_W'(1) << B_LD_BEN;
    localparam logic [CW_W-1:0] LD_REG       = CW_W'(1) << B_LD_REG;
    localparam logic [CW_W-1:0] LD_CC        = CW_W'(1) << B_LD_CC;
    localparam logic [CW_W-1:0] LD_PC        = CW_W'(1) << B_LD_PC;
    localparam logic [CW_W-1:0] GATE_PC      = CW_W'(1) << B_GATE_PC;
    localparam logic [CW_W-1:0] GATE_MDR     = CW_W'(1) << B_GATE_MDR;
    localparam logic [CW_W-1:0] GATE_ALU     = CW_W'(1) << B_GATE_ALU;
    localparam logic [CW_W-1:0] GATE_MARMUX  = CW_W'(1) << B_GATE_MARMUX;
    localparam logic [CW_W-1:0] GATE_SHF     = CW_W'(1) << B_GATE_SHF;
    localparam logic [CW_W-1:0] PCMUX_BUS    = CW_W'(1) << B_PCMUX;
    localparam logic [CW_W-1:0] PCMUX_ADDER  = CW_W'(2) << B_PCMUX;
    localparam logic [CW_W-1:0] DRMUX_R7     = CW_W'(1) << B_DRMUX;
    localparam logic [CW_W-1:0] SR1MUX_86    = CW_W'(1) << B_SR1MUX;
    localparam logic [CW_W-1:0] ADDR1_SR1    = CW_W'(1) << B_ADDR1MUX;
    localparam logic [CW_W-1:0] ADDR2_OFF6   = CW_W'(1) << B_ADDR2MUX;
    localparam logic [CW_W-1:0] ADDR2_OFF9   = CW_W'(2) << B_ADDR2MUX;
    localparam logic [CW_W-1:0] ADDR2_OFF11  = CW_W'(3) << B_ADDR2MUX;
    localparam logic [CW_W-1:0] MARMUX_ADDER = CW_W'(1) << B_MARMUX;
    localparam logic [CW_W-1:0] ALUK_AND     = CW_W'(1) << B_ALUK;
    localparam logic [CW_W-1:0] ALUK_XOR     = CW_W'(2) << B_ALUK;
    localparam logic [CW_W-1:0] ALUK_PASSA   = CW_W'(3) << B_ALUK;
    localparam logic [CW_W-1:0] MIO_EN       = CW_W'(1) << B_MIO_EN;
    localparam logic [CW_W-1:0] R_W_WRITE    = CW_W'(1) << B_R_W;
    localparam logic [CW_W-1:0] DATA_WORD    = CW_W'(1) << B_DATA_SIZE;
    localparam logic [CW_W-1:0] LSHF1        = CW_W'(1) << B_LSHF1;

    // Shared words: ALU ops, base+offset6 address, memory write-back
    localparam logic [CW_W-1:0] CW_ALU_OP  = LD_REG | LD_CC | GATE_ALU | SR1MUX_86;
    localparam logic [CW_W-1:0] CW_EA_B6   = LD_MAR | GATE_MARMUX | MARMUX_ADDER |
                                             ADDR1_SR1 | ADDR2_OFF6 | SR1MUX_86;
    localparam logic [CW_W-1:0] CW_MEM_WB  = LD_REG | LD_CC | GATE_MDR;
    localparam logic [CW_W-1:0] CW_PC_BASE = LD_PC | PCMUX_ADDER | ADDR1_SR1 | SR1MUX_86;
    localparam logic [CW_W-1:0] CW_ST_MDR  = LD_MDR | GATE_ALU | ALUK_PASSA;

    function automatic uinst_t mk(input logic [CW_W-1:0] cw, input cond_e cond,
                                  input logic [STATE_W-1:0] j);
        uinst_t u;
        u.cw   = cw;
        u.ird  = 1'b0;
        u.cond = cond;
        u.j    = j;
        return u;
    endfunction

    // Control store; memory-wait states loop on J and exit to J|2 when R=1
    function automatic uinst_t ucode_rom(input logic [STATE_W-1:0] s);
        uinst_t u;
        u = mk('0, COND_NONE, S_FETCH0);
        case (s)
            S_FETCH0:   u = mk(LD_MAR | LD_PC | GATE_PC, COND_NONE, S_FETCH1);
            S_FETCH1:   u = mk(LD_MDR | MIO_EN | DATA_WORD, COND_MEM_R, S_FETCH1);
            S_FETCH2:   u = mk(LD_IR | GATE_MDR, COND_NONE, S_DECODE);
            S_DECODE: begin
                u     = mk(LD_BEN, COND_NONE, S_FETCH0);
                u.ird = 1'b1;
            end
            S_BR:       u = mk('0, COND_BEN, S_FETCH0);
            S_BR_TAKEN: u = mk(LD_PC | PCMUX_ADDER | ADDR2_OFF9 | LSHF1, COND_NONE, S_FETCH0);
            S_ADD:      u = mk(CW_ALU_OP, COND_NONE, S_FETCH0);
            S_AND:      u = mk(CW_ALU_OP | ALUK_AND, COND_NONE, S_FETCH0);
            S_XOR:      u = mk(CW_ALU_OP | ALUK_XOR, COND_NONE, S_FETCH0);
            S_SHF:      u = mk(LD_REG | LD_CC | GATE_SHF | SR1MUX_86, COND_NONE, S_FETCH0);
            S_LEA:      u = mk(LD_REG | GATE_MARMUX | MARMUX_ADDER | ADDR2_OFF9 | LSHF1,
                               COND_NONE, S_FETCH0);
            S_JMP:      u = mk(CW_PC_BASE, COND_NONE, S_FETCH0);
            S_JSR:      u = mk(LD_REG | GATE_PC | DRMUX_R7, COND_IR11, S_JSRR);
            S_JSRR:     u = mk(CW_PC_BASE, COND_NONE, S_FETCH0);
            S_JSR_OFF:  u = mk(LD_PC | PCMUX_ADDER | ADDR2_OFF11 | LSHF1, COND_NONE, S_FETCH0);
            S_LDB:      u = mk(CW_EA_B6, COND_NONE, S_LDB_MEM);
            S_LDB_MEM:  u = mk(LD_MDR | MIO_EN, COND_MEM_R, S_LDB_MEM);
            S_LDB_WB:   u = mk(CW_MEM_WB, COND_NONE, S_FETCH0);
            S_LDW:      u = mk(CW_EA_B6 | LSHF1, COND_NONE, S_LDW_MEM);
            S_LDW_MEM:  u = mk(LD_MDR | MIO_EN | DATA_WORD, COND_MEM_R, S_LDW_MEM);
            S_LDW_WB:   u = mk(CW_MEM_WB, COND_NONE, S_FETCH0);
            S_STB:      u = mk(CW_EA_B6, COND_NONE, S_STB_MDR);
            S_STB_MDR:  u = mk(CW_ST_MDR, COND_NONE, S_STB_MEM);
            S_STB_MEM:  u = mk(MIO_EN | R_W_WRITE, COND_MEM_R, S_STB_MEM);
            S_STB_DONE: u = mk('0, COND_NONE, S_FETCH0);
            S_STW:      u = mk(CW_EA_B6 | LSHF1, COND_NONE, S_STW_MDR);
            S_STW_MDR:  u = mk(CW_ST_MDR, COND_NONE, S_STW_MEM);
            S_STW_MEM:  u = mk(MIO_EN | R_W_WRITE | DATA_WORD, COND_MEM_R, S_STW_MEM);
            S_TRAP:     u = mk(LD_MAR | GATE_MARMUX, COND_NONE, S_TRAP_MEM);
            S_TRAP_MEM: u = mk(LD_MDR | MIO_EN | DATA_WORD | LD_REG | GATE_PC | DRMUX_R7,
                               COND_MEM_R, S_TRAP_MEM);
            S_TRAP_PC:  u = mk(LD_PC | GATE_MDR | PCMUX_BUS, COND_NONE, S_FETCH0);
            default: ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/lc3b_microsequencer_if.sv
// Sequencer <-> datapath bundle: feedback from the datapath, control word back.
interface lc3b_microsequencer_if;
    import lc3b_ctrl_pkg::*;

    logic [15:0]        ir;
    logic               r;
    logic               n;
    logic               z;
    logic               p;
    logic [CW_W-1:0]    control_signals;
    logic [STATE_W-1:0] state;
    logic               ben;

    modport master (input ir, r, n, z, p, output control_signals, state, ben);
    modport slave  (output ir, r, n, z, p, input control_signals, state, ben);
endinterface

// File: rtl/lc3b_microsequencer_next_state.sv
// Combinational next-microstate selection and BEN input for the LC-3b sequencer.
module lc3b_next_state
    import lc3b_ctrl_pkg::*;
(
    input  logic               ird_i,
    input  cond_e              cond_i,
    input  logic [STATE_W-1:0] j_i,
    input  logic               ld_ben_i,
    input  logic [6:0]         ir_hi_i,   // ir[15:9]
    input  logic               r_i,
    input  logic               n_i,
    input  logic               z_i,
    input  logic               p_i,
    input  logic               ben_i,
    output logic [STATE_W-1:0] next_state_c_o,
    output logic               ben_next_c_o
);

    always_comb begin
        next_state_c_o = j_i;
        if (ird_i) begin
            next_state_c_o = STATE_W'({2'b00, ir_hi_i[6:3]});
        end else begin
            case (cond_i)
                COND_MEM_R: next_state_c_o[1] = j_i[1] | r_i;
                COND_BEN:   next_state_c_o[2] = j_i[2] | ben_i;
                COND_IR11:  next_state_c_o[0] = j_i[0] | ir_hi_i[2];
                default: ;
            endcase
        end
    end

    always_comb begin
        ben_next_c_o = ben_i;
        if (ld_ben_i) begin
            ben_next_c_o = (ir_hi_i[2] & n_i) | (ir_hi_i[1] & z_i) | (ir_hi_i[0] & p_i);
        end
    end

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: microstate and BEN registers plus control-store lookup.
module lc3b_microsequencer
    import lc3b_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    lc3b_microsequencer_if.master  bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               ben_q, ben_d;
    uinst_t             uinst_c;

    always_comb begin
        uinst_c = ucode_rom(state_q);
    end

    lc3b_next_state u_next_state (
        .ird_i          (uinst_c.ird),
        .cond_i         (uinst_c.cond),
        .j_i            (uinst_c.j),
        .ld_ben_i       (uinst_c.cw[B_LD_BEN]),
        .ir_hi_i        (bus.ir[15:9]),
        .r_i            (bus.r),
        .n_i            (bus.n),
        .z_i            (bus.z),
        .p_i            (bus.p),
        .ben_i          (ben_q),
        .next_state_c_o (state_d),
        .ben_next_c_o   (ben_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STATE_W'(RESET_STATE);
            ben_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ben_q   <= ben_d;
        end
    end

    // Moore output: the control word is decoded straight from the state register
    assign bus.control_signals = uinst_c.cw;
    assign bus.state           = state_q;
    assign bus.ben             = ben_q;

endmodule

// File: tb/tb_lc3b_microsequencer.sv
// Bench for lc3b_microsequencer: directed walk through fetch/decode/branch/reset
// cases, then a randomized run checked every cycle against an instruction-flow model.
module tb_lc3b_microsequencer;
    import lc3b_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    lc3b_microsequencer_if bus ();

    lc3b_microsequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state  = 18;
    logic m_ben    = 1'b0;
    logic done     = 1'b0;

    localparam logic [25:0] T_LD_MAR = 26'h2000000, T_LD_MDR = 26'h1000000,
                            T_LD_IR  = 26'h0800000, T_LD_BEN = 26'h0400000,
                            T_LD_REG = 26'h0200000, T_LD_CC  = 26'h0100000,
                            T_LD_PC  = 26'h0080000, T_G_PC   = 26'h0040000,
                            T_G_MDR  = 26'h0020000, T_G_ALU  = 26'h0010000,
                            T_G_MARM = 26'h0008000, T_G_SHF  = 26'h0004000,
                            T_PC_BUS = 26'h0001000, T_PC_ADD = 26'h0002000,
                            T_DR_R7  = 26'h0000800, T_SR1_86 = 26'h0000400,
                            T_A1_SR1 = 26'h0000200, T_A2_6   = 26'h0000080,
                            T_A2_9   = 26'h0000100, T_A2_11  = 26'h0000180,
                            T_MAR_AD = 26'h0000040, T_AND    = 26'h0000010,
                            T_XOR    = 26'h0000020, T_PASSA  = 26'h0000030,
                            T_MIO    = 26'h0000008, T_WR     = 26'h0000004,
                            T_WORD   = 26'h0000002, T_LSHF   = 26'h0000001;

    // Expected control word of each microstate, by what the state does
    function automatic logic [25:0] exp_cw(input int s);
        case (s)
            18:      return T_LD_MAR | T_LD_PC | T_G_PC;
            33, 25:  return T_LD_MDR | T_MIO | T_WORD;
            29:      return T_LD_MDR | T_MIO;
            35:      return T_LD_IR | T_G_MDR;
            32:      return T_LD_BEN;
            22:      return T_LD_PC | T_PC_ADD | T_A2_9 | T_LSHF;
            1:       return T_LD_REG | T_LD_CC | T_G_ALU | T_SR1_86;
            5:       return T_LD_REG | T_LD_CC | T_G_ALU | T_SR1_86 | T_AND;
            9:       return T_LD_REG | T_LD_CC | T_G_ALU | T_SR1_86 | T_XOR;
            13:      return T_LD_REG | T_LD_CC | T_G_SHF | T_SR1_86;
            14:      return T_LD_REG | T_G_MARM | T_MAR_AD | T_A2_9 | T_LSHF;
            12, 20:  return T_LD_PC | T_PC_ADD | T_A1_SR1 | T_SR1_86;
            4:       return T_LD_REG | T_G_PC | T_DR_R7;
            21:      return T_LD_PC | T_PC_ADD | T_A2_11 | T_LSHF;
            2, 3:    return T_LD_MAR | T_G_MARM | T_MAR_AD | T_A1_SR1 | T_A2_6 | T_SR1_86;
            6, 7:    return T_LD_MAR | T_G_MARM | T_MAR_AD | T_A1_SR1 | T_A2_6 | T_SR1_86 | T_LSHF;
            31, 27:  return T_LD_REG | T_LD_CC | T_G_MDR;
            24, 23:  return T_LD_MDR | T_G_ALU | T_PASSA;
            17:      return T_MIO | T_WR;
            16:      return T_MIO | T_WR | T_WORD;
            15:      return T_LD_MAR | T_G_MARM;
            28:      return T_LD_MDR | T_MIO | T_WORD | T_LD_REG | T_G_PC | T_DR_R7;
            30:      return T_LD_PC | T_G_MDR | T_PC_BUS;
            default: return 26'h0;
        endcase
    endfunction

    // Instruction-flow model: where each microstate goes next
    function automatic int model_next(input int s, input logic [15:0] ir,
                                      input logic r, input logic ben);
        case (s)
            18: return 33;
            33: return r ? 35 : 33;
            35: return 32;
            32: return int'(ir[15:12]);
            0:  return ben ? 22 : 18;
            4:  return ir[11] ? 21 : 20;
            2:  return 29;
            29: return r ? 31 : 29;
            6:  return 25;
            25: return r ? 27 : 25;
            3:  return 24;
            24: return 17;
            17: return r ? 19 : 17;
            7:  return 23;
            23: return 16;
            16: return r ? 18 : 16;
            15: return 28;
            28: return r ? 30 : 28;
            default: return 18;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_gates(input string name, input logic [25:0] cw);
        n_checks++;
        if ($countones(cw[18:14]) > 1) begin
            n_errors++;
            $display("FAIL %s: gate bits 0x%0h have more than one set", name, cw[18:14]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= 18;
            m_ben   <= 1'b0;
        end else begin
            m_state <= model_next(m_state, bus.ir, bus.r, m_ben);
            if (m_state == 32)
                m_ben <= |(bus.ir[11:9] & {bus.n, bus.z, bus.p});
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("model_state", 32'(bus.state), 32'(m_state));
            chk("model_ben", 32'(bus.ben), 32'(m_ben));
            chk("model_cw", 32'(bus.control_signals), 32'(exp_cw(m_state)));
            chk_gates("model_gates", bus.control_signals);
        end
    end

    initial begin
        bus.ir = 16'h0;
        bus.r  = 1'b0;
        bus.n  = 1'b0;
        bus.z  = 1'b0;
        bus.p  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(bus.state), 32'd18);
        chk("rst_ben", 32'(bus.ben), 32'd0);
        chk("rst_cw", 32'(bus.control_signals), 32'h20C0000);

        reset = 1'b1;
        tick();
        chk("fetch1_state", 32'(bus.state), 32'd33);
        chk("fetch1_cw", 32'(bus.control_signals), 32'h100000A);
        repeat (3) tick();
        chk("mem_wait_state", 32'(bus.state), 32'd33);
        bus.r = 1'b1;
        tick();
        chk("fetch2_state", 32'(bus.state), 32'd35);
        chk("fetch2_cw", 32'(bus.control_signals), 32'h0820000);

        bus.ir = 16'h1042;
        tick();
        chk("decode_state", 32'(bus.state), 32'd32);
        chk("decode_cw", 32'(bus.control_signals), 32'h0400000);
        tick();
        chk("add_state", 32'(bus.state), 32'd1);
        chk("add_ld_reg", 32'(bus.control_signals[21]), 32'd1);
        chk("add_ld_cc", 32'(bus.control_signals[20]), 32'd1);
        chk("add_gate_alu", 32'(bus.control_signals[16]), 32'd1);
        chk("add_cw", 32'(bus.control_signals), 32'h0310400);
        tick();
        chk("add_return", 32'(bus.state), 32'd18);

        bus.ir = 16'h0A05;
        bus.n  = 1'b1;
        repeat (4) tick();
        chk("brnp_n_state", 32'(bus.state), 32'd0);
        chk("brnp_n_ben", 32'(bus.ben), 32'd1);
        tick();
        chk("br_taken_state", 32'(bus.state), 32'd22);
        chk("br_taken_cw", 32'(bus.control_signals), 32'h0082101);
        tick();
        chk("br_taken_return", 32'(bus.state), 32'd18);

        bus.r = 1'b0;
        repeat (2) tick();
        chk("wait_before_reset", 32'(bus.state), 32'd33);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state), 32'd18);
        chk("async_rst_ben", 32'(bus.ben), 32'd0);
        chk("async_rst_cw", 32'(bus.control_signals), 32'h20C0000);
        tick();
        chk("held_rst_state", 32'(bus.state), 32'd18);
        reset = 1'b1;
        tick();
        chk("restart_state", 32'(bus.state), 32'd33);

        bus.n = 1'b0;
        bus.z = 1'b1;
        bus.r = 1'b1;
        repeat (3) tick();
        chk("brnp_z_state", 32'(bus.state), 32'd0);
        chk("brnp_z_ben", 32'(bus.ben), 32'd0);
        tick();
        chk("br_not_taken", 32'(bus.state), 32'd18);

        bus.ir = 16'hA000;
        repeat (4) tick();
        chk("illegal_state", 32'(bus.state), 32'd10);
        chk("illegal_cw", 32'(bus.control_signals), 32'h0);
        tick();
        chk("illegal_recover", 32'(bus.state), 32'd18);

        for (int s = 0; s < 64; s++) begin
            uinst_t u;
            u = ucode_rom(6'(s));
            chk($sformatf("rom_cw_%0d", s), 32'(u.cw), 32'(exp_cw(s)));
            chk_gates($sformatf("rom_gates_%0d", s), u.cw);
        end

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            if (!reset)
                reset = 1'b1;
            else if ($urandom_range(0, 199) == 0)
                reset = 1'b0;
            bus.ir = 16'($urandom);
            bus.r  = ($urandom_range(0, 2) != 0);
            bus.n  = 1'($urandom);
            bus.z  = 1'($urandom);
            bus.p  = 1'($urandom);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
